display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner.sv | 183 ++++++++++++++++++
 tb/tb_display_scanner.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Four-digit seven-segment scanner. A synchronized 120 Hz tick advances the
// digit index; each digit slot is preceded by an all-anodes-off blanking gap
// so segment changes never ghost onto the neighbouring digit. A full 4-digit
// snapshot is taken whenever the index wraps to digit 0.
module display_scanner #(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Clk_120Hz,
  input  logic [15:0] i_Digits,
  input  logic [3:0]  i_Dp,
  input  logic [3:0]  i_Blank,
  output logic [3:0]  o_Anodes,
  output logic [6:0]  o_Segments,
  output logic        o_Dp,
  output logic        o_Frame
);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  localparam logic [7:0] LastCnt = 8'(BLANK_CYCLES - 1);

  // Synchronizer, history flop and a validity shift that marks when s3 holds
  // real sampled data (blocks a false tick if the input is high at release).
  logic       r_s1, r_s2, r_s3;
  logic [2:0] r_vld;
  logic       w_tick;

  state_e      r_state, w_state_d;
  logic [1:0]  r_idx, w_idx_d, w_idx_inc;
  logic [7:0]  r_cnt, w_cnt_d;
  logic [15:0] r_frame_digits, w_frame_digits_d;
  logic [3:0]  r_frame_dp, w_frame_dp_d;
  logic [3:0]  r_frame_blank, w_frame_blank_d;
  logic [3:0]  r_anodes, w_anodes_d;
  logic [6:0]  r_segments, w_segments_d;
  logic        r_dp, w_dp_d;
  logic        r_frame, w_frame_d;

  function automatic logic [6:0] f_decode(input logic [3:0] i_nib);
    logic [6:0] v;
    unique case (i_nib)
      4'h0: v = 7'b1000000;
      4'h1: v = 7'b1111001;
      4'h2: v = 7'b0100100;
      4'h3: v = 7'b0110000;
      4'h4: v = 7'b0011001;
      4'h5: v = 7'b0010010;
      4'h6: v = 7'b0000010;
      4'h7: v = 7'b1111000;
      4'h8: v = 7'b0000000;
      4'h9: v = 7'b0010000;
      4'hA: v = 7'b0001000;
      4'hB: v = 7'b0000011;
      4'hC: v = 7'b1000110;
      4'hD: v = 7'b0100001;
      4'hE: v = 7'b0000110;
      4'hF: v = 7'b0001110;
    endcase
    return v;
  endfunction

  // Input synchronizer and edge-history registers.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_vld <= 3'b000;
    end else begin
      r_s1  <= i_Clk_120Hz;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_vld <= {r_vld[1:0], 1'b1};
    end
  end

  assign w_tick    = r_s2 & ~r_s3 & r_vld[2];
  assign w_idx_inc = r_idx + 2'd1;

  // Scan state, frame snapshot and registered display outputs.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state        <= StIdle;
      r_idx          <= 2'd0;
      r_cnt          <= 8'd0;
      r_frame_digits <= 16'h0000;
      r_frame_dp     <= 4'h0;
      r_frame_blank  <= 4'h0;
      r_anodes       <= 4'b1111;
      r_segments     <= 7'b1111111;
      r_dp           <= 1'b1;
      r_frame        <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_idx          <= w_idx_d;
      r_cnt          <= w_cnt_d;
      r_frame_digits <= w_frame_digits_d;
      r_frame_dp     <= w_frame_dp_d;
      r_frame_blank  <= w_frame_blank_d;
      r_anodes       <= w_anodes_d;
      r_segments     <= w_segments_d;
      r_dp           <= w_dp_d;
      r_frame        <= w_frame_d;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so they change on the same edge as the state.
  always_comb begin
    w_state_d        = r_state;
    w_idx_d          = r_idx;
    w_cnt_d          = r_cnt;
    w_frame_digits_d = r_frame_digits;
    w_frame_dp_d     = r_frame_dp;
    w_frame_blank_d  = r_frame_blank;
    w_anodes_d       = r_anodes;
    w_segments_d     = r_segments;
    w_dp_d           = r_dp;
    w_frame_d        = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_anodes_d   = 4'b1111;
        w_segments_d = 7'b1111111;
        w_dp_d       = 1'b1;
        if (w_tick) begin
          w_state_d        = StBlank;
          w_idx_d          = 2'd0;
          w_cnt_d          = 8'd0;
          w_frame_digits_d = i_Digits;
          w_frame_dp_d     = i_Dp;
          w_frame_blank_d  = i_Blank;
          w_frame_d        = 1'b1;
          w_segments_d     = f_decode(i_Digits[3:0]);
          w_dp_d           = ~i_Dp[0];
        end
      end
      StBlank: begin
        // Ticks here are dropped: neither index nor count is touched.
        w_anodes_d = 4'b1111;
        if (r_cnt == LastCnt) begin
          w_state_d  = StShow;
          w_anodes_d = r_frame_blank[r_idx] ? 4'b1111 : ~(4'b0001 << r_idx);
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StShow: begin
        if (w_tick) begin
          w_state_d  = StBlank;
          w_idx_d    = w_idx_inc;
          w_cnt_d    = 8'd0;
          w_anodes_d = 4'b1111;
          if (w_idx_inc == 2'd0) begin
            w_frame_digits_d = i_Digits;
            w_frame_dp_d     = i_Dp;
            w_frame_blank_d  = i_Blank;
            w_frame_d        = 1'b1;
            w_segments_d     = f_decode(i_Digits[3:0]);
            w_dp_d           = ~i_Dp[0];
          end else begin
            w_segments_d = f_decode(r_frame_digits[{w_idx_inc, 2'b00} +: 4]);
            w_dp_d       = ~r_frame_dp[w_idx_inc];
          end
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_anodes_d   = 4'b1111;
        w_segments_d = 7'b1111111;
        w_dp_d       = 1'b1;
      end
    endcase
  end

  assign o_Anodes   = r_anodes;
  assign o_Segments = r_segments;
  assign o_Dp       = r_dp;
  assign o_Frame    = r_frame;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with hand-computed segment patterns.
module tb_display_scanner;

  logic        i_Clk;
  logic        i_Reset;
  logic        i_Clk_120Hz;
  logic [15:0] i_Digits;
  logic [3:0]  i_Dp;
  logic [3:0]  i_Blank;
  logic [3:0]  o_Anodes;
  logic [6:0]  o_Segments;
  logic        o_Dp;
  logic        o_Frame;

  int n_checks = 0;
  int n_errors = 0;
  int n_frames = 0;
  int n_multi  = 0;

  display_scanner #(.BLANK_CYCLES(4)) u_dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Clk_120Hz (i_Clk_120Hz),
    .i_Digits    (i_Digits),
    .i_Dp        (i_Dp),
    .i_Blank     (i_Blank),
    .o_Anodes    (o_Anodes),
    .o_Segments  (o_Segments),
    .o_Dp        (o_Dp),
    .o_Frame     (o_Frame)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Frame pulse count and anode one-cold watch, sampled mid-cycle.
  always @(negedge i_Clk) begin
    if (o_Frame) n_frames++;
    if ($countones(~o_Anodes) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clean 120 Hz pulse: the rise is sampled at p1, tick acts at p3,
  // BLANK spans p3..p7 and the digit lights at p7.
  task automatic step_digit(input string tag, input logic [3:0] an, input logic [6:0] seg,
                            input logic dp);
    @(posedge i_Clk); #1 i_Clk_120Hz = 1'b1;
    repeat (6) @(posedge i_Clk);
    @(negedge i_Clk);
    check({tag, "_blank_an"}, 32'(o_Anodes), 32'hF);
    check({tag, "_pre_seg"}, 32'(o_Segments), 32'(seg));
    @(posedge i_Clk);
    @(negedge i_Clk);
    check({tag, "_an"}, 32'(o_Anodes), 32'(an));
    check({tag, "_seg"}, 32'(o_Segments), 32'(seg));
    check({tag, "_dp"}, 32'(o_Dp), 32'(dp));
    #1 i_Clk_120Hz = 1'b0;
    repeat (4) @(posedge i_Clk);
  endtask

  initial begin
    i_Reset     = 1'b1;
    i_Clk_120Hz = 1'b0;
    i_Digits    = 16'h1234;
    i_Dp        = 4'b0100;
    i_Blank     = 4'b0000;
    #1 i_Reset = 1'b0;
    #1;
    check("rst_an", 32'(o_Anodes), 32'hF);
    check("rst_seg", 32'(o_Segments), 32'h7F);
    check("rst_dp", 32'(o_Dp), 32'h1);
    check("rst_frame", 32'(o_Frame), 32'h0);
    repeat (3) @(posedge i_Clk);
    #1 i_Reset = 1'b1;

    // Idle with a quiet prescaler input.
    repeat (100) @(posedge i_Clk);
    @(negedge i_Clk);
    check("idle_an", 32'(o_Anodes), 32'hF);
    check("idle_seg", 32'(o_Segments), 32'h7F);
    check("idle_dp", 32'(o_Dp), 32'h1);
    check("idle_frames", 32'(n_frames), 32'd0);

    // Scan 1234, dp on digit 2.
    step_digit("d0", 4'b1110, 7'b0011001, 1'b1);
    check("frames_a", 32'(n_frames), 32'd1);
    step_digit("d1", 4'b1101, 7'b0110000, 1'b1);
    i_Digits = 16'hABCD;
    step_digit("d2", 4'b1011, 7'b0100100, 1'b0);
    step_digit("d3", 4'b0111, 7'b1111001, 1'b1);
    check("frames_b", 32'(n_frames), 32'd1);
    step_digit("e0", 4'b1110, 7'b0100001, 1'b1);
    check("frames_c", 32'(n_frames), 32'd2);
    step_digit("e1", 4'b1101, 7'b1000110, 1'b1);
    step_digit("e2", 4'b1011, 7'b0000011, 1'b0);
    step_digit("e3", 4'b0111, 7'b0001000, 1'b1);

    // Second tick lands inside BLANK and must be dropped.
    @(posedge i_Clk); #1 i_Clk_120Hz = 1'b1;
    @(posedge i_Clk); #1 i_Clk_120Hz = 1'b0;
    @(posedge i_Clk); #1 i_Clk_120Hz = 1'b1;
    repeat (4) @(posedge i_Clk);
    @(negedge i_Clk);
    check("dbl_blank_an", 32'(o_Anodes), 32'hF);
    @(posedge i_Clk);
    @(negedge i_Clk);
    check("dbl_an", 32'(o_Anodes), 32'hE);
    check("dbl_seg", 32'(o_Segments), 32'(7'b0100001));
    #1 i_Clk_120Hz = 1'b0;
    repeat (4) @(posedge i_Clk);
    step_digit("dbl_next", 4'b1101, 7'b1000110, 1'b1);
    check("frames_d", 32'(n_frames), 32'd3);

    // Reset while showing digit 2, released with the prescaler high.
    step_digit("r2", 4'b1011, 7'b0000011, 1'b0);
    @(posedge i_Clk); #3 i_Reset = 1'b0;
    #1;
    check("midrst_an", 32'(o_Anodes), 32'hF);
    check("midrst_seg", 32'(o_Segments), 32'h7F);
    check("midrst_dp", 32'(o_Dp), 32'h1);
    i_Clk_120Hz = 1'b1;
    repeat (3) @(posedge i_Clk);
    #1 i_Reset = 1'b1;
    repeat (20) @(posedge i_Clk);
    @(negedge i_Clk);
    check("rel_hi_an", 32'(o_Anodes), 32'hF);
    check("rel_hi_frames", 32'(n_frames), 32'd3);
    #1 i_Clk_120Hz = 1'b0;
    i_Digits = 16'h8888;
    i_Dp     = 4'b0000;
    i_Blank  = 4'b1010;
    repeat (5) @(posedge i_Clk);

    // Blanked digit slots keep anodes high while the index still advances.
    step_digit("b0", 4'b1110, 7'b0000000, 1'b1);
    step_digit("b1", 4'b1111, 7'b0000000, 1'b1);
    step_digit("b2", 4'b1011, 7'b0000000, 1'b1);
    step_digit("b3", 4'b1111, 7'b0000000, 1'b1);
    step_digit("b0w", 4'b1110, 7'b0000000, 1'b1);
    check("frames_e", 32'(n_frames), 32'd5);
    check("one_anode", 32'(n_multi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
